multi_dice: RTL and testbench
=============================

Name: multi_dice

Overview:
- Parametrised electronic dice roller: N_DICE independent dice, each with FACES faces.
- Dice roll while a debounced button is held, freeze on release, then publish a result with a valid/ack handshake, plus the dice sum and a doubles flag.
- Sits between a raw push-button input and display/score logic in the dice/games area of the design.

Parameters:
- N_DICE, 2, number of dice (>=1).
- FACES, 6, faces per die (>=2); face values are 1..FACES.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before the debounced button changes (>=1).
- W, $clog2(FACES+1), derived per-die value width; not overridden.
- SW, $clog2(N_DICE*FACES+1), derived sum width; not overridden.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- button  in  1  raw asynchronous push-button, bouncy.
- result_ack  in  1  consumer accepts the current result.
- throw  out  N_DICE*W  packed die values; die i is in throw[i*W +: W].
- sum  out  SW  sum of all die values, combinational from the throw registers.
- rolling  out  1  high while the FSM is in ROLLING.
- result_valid  out  1  frozen result available.
- doubles  out  1  all dice equal; meaningful only while result_valid is high.

Behaviour:
- Reset (rst=1 at posedge) forces:
  - every die to 1; sum = N_DICE;
  - FSM to IDLE; rolling=0, result_valid=0;
  - sync flops and debounced button to 0; debounce counter to 0.
- Reset mid-roll aborts the roll with no result.
- Synchroniser: button passes through 2 flops to give btn_s.
- Debounce:
  - Counter increments each cycle btn_s != btn_db; it clears whenever they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and the two still differ, btn_db flips and the counter clears.
  - btn_db therefore changes DEBOUNCE_CYCLES cycles after btn_s first differs.
  - Any glitch shorter than that is ignored.
- FSM with two states:
  - IDLE -> ROLLING on a posedge with btn_db=1. Dice do not step on this edge. result_valid clears on this edge, overriding ack.
  - ROLLING, btn_db=1: on every posedge, each die steps.
  - ROLLING -> IDLE on a posedge with btn_db=0. No step on this edge; result_valid set to 1.
- Stepping rule:
  - Die i adds STEP_i = (i mod (FACES-1)) + 1.
  - If v + STEP_i > FACES, the new value is v + STEP_i - FACES; otherwise v + STEP_i.
  - Values never leave 1..FACES; the wrap never skips into 0.
  - Distinct steps decorrelate the dice.
- result_valid:
  - Held until a posedge with result_ack=1 while in IDLE.
  - Ack while result_valid=0 is ignored.
  - Ack in the same cycle as the IDLE->ROLLING transition leaves result_valid=0.
  - A new roll while a result is unacknowledged drops the old result; there is no queueing.
- throw holds its value in IDLE.
- doubles = 1 when all dice are equal (N_DICE=1 gives doubles=1). Combinational, gated by result_valid.
- End-to-end latency: a clean press reaches ROLLING 2 + DEBOUNCE_CYCLES + 1 posedges after button rises; release behaves symmetrically.
- Elaboration must fail if FACES<2, N_DICE<1 or DEBOUNCE_CYCLES<1.

Decomposition:
- Package dice_pkg holds:
  - the state enum (IDLE, ROLLING);
  - the step function step_of(i, FACES);
  - the wrap-add function wrap_add(v, step, FACES).
- One sub-module, dice_debounce (2-flop synchroniser plus counter, parameter DEBOUNCE_CYCLES), instantiated once.
- Dice registers come from a generate loop in multi_dice.

Test Plan (N_DICE=2, FACES=6, DEBOUNCE_CYCLES=4 unless stated):
- rst held 3 cycles with button=1 -> throw={1,1}, sum=2, rolling=0, result_valid=0; then release rst -> rolling rises exactly 7 posedges later.
- button pulses high for 3 cycles, then low -> rolling never asserts, throw stays {1,1}.
- Button held so that ROLLING lasts exactly 7 stepping edges, then released -> die0=2, die1=3, sum=5, doubles=0, result_valid=1 until result_ack.
- ROLLING lasts exactly 6 stepping edges -> die0=1, die1=1, sum=2, doubles=1.
- FACES=3, N_DICE=3, 4 stepping edges -> steps {1,2,1}; die values {2,3,2}, all within 1..3.
- rst asserted during ROLLING -> next cycle throw={1,1}, rolling=0, result_valid=0.
- New press with result unacked -> result_valid drops on entering ROLLING; ack in that same cycle has no effect.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and arithmetic for the multi-die roller: FSM states, per-die
// step size and the 1..FACES wrap-around add.
package dice_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    ROLLING = 1'b1
  } state_t;

  // Distinct step per die so neighbouring dice do not move in lockstep.
  function automatic int step_of(input int i, input int faces);
    return (i % (faces - 1)) + 1;
  endfunction

  // Faces run 1..faces, so the wrap subtracts faces and never lands on 0.
  function automatic int wrap_add(input int v, input int step, input int faces);
    return (v + step > faces) ? (v + step - faces) : (v + step);
  endfunction

endpackage

// File: rtl/dice_debounce.sv
// Two-flop synchroniser for the raw button followed by a stability counter;
// level only changes after DEBOUNCE_CYCLES consecutive differing samples.
module dice_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_1;
  logic          btn_s;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_1 <= button;
      btn_s  <= sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b0;
      cnt    <= '0;
    end else if (btn_s == btn_db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_dice.sv
// N_DICE dice that step while the debounced button is held, freeze on
// release and publish the frozen throw with a valid/ack handshake.
module multi_dice
  import dice_pkg::*;
#(
  parameter  int N_DICE          = 2,
  parameter  int FACES           = 6,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int W               = $clog2(FACES + 1),
  localparam int SW              = $clog2(N_DICE * FACES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              result_ack,
  output logic [N_DICE*W-1:0] throw,
  output logic [SW-1:0]     sum,
  output logic              rolling,
  output logic              result_valid,
  output logic              doubles
);

  if (FACES < 2) begin : g_bad_faces
    $error("multi_dice: FACES must be >= 2");
  end
  if (N_DICE < 1) begin : g_bad_n_dice
    $error("multi_dice: N_DICE must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("multi_dice: DEBOUNCE_CYCLES must be >= 1");
  end

  logic   btn_db;
  state_t state_q, state_d;
  logic   valid_d;
  logic   step_en;

  dice_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .btn_db(btn_db)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_valid <= valid_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    valid_d = result_valid;
    unique case (state_q)
      IDLE: begin
        if (btn_db) begin
          state_d = ROLLING;
          valid_d = 1'b0;          // a new roll drops any unacked result
        end else if (result_ack) begin
          valid_d = 1'b0;
        end
      end
      ROLLING: begin
        if (!btn_db) begin
          state_d = IDLE;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rolling = (state_q == ROLLING);
  // Entry and exit edges see btn_db disagree with "stay rolling", so no step.
  assign step_en = (state_q == ROLLING) && btn_db;

  for (genvar i = 0; i < N_DICE; i++) begin : g_die
    localparam int STEP = step_of(i, FACES);
    logic [W-1:0] val;

    always_ff @(posedge clk) begin
      if (rst) begin
        val <= W'(1);
      end else if (step_en) begin
        val <= W'(wrap_add(int'(val), STEP, FACES));
      end
    end

    assign throw[i*W +: W] = val;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_DICE; i++) begin
      sum = sum + SW'(throw[i*W +: W]);
    end
  end

  logic all_equal;
  always_comb begin
    all_equal = 1'b1;
    for (int i = 1; i < N_DICE; i++) begin
      if (throw[i*W +: W] != throw[0 +: W]) all_equal = 1'b0;
    end
  end

  assign doubles = result_valid & all_equal;

endmodule

// File: tb/tb_multi_dice.sv
// Bench for multi_dice: a 2x6 instance and a 3x3 instance share stimulus and
// are compared every cycle against a stepping-count reference model.
module tb_multi_dice;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       result_ack;

  logic [5:0] throw_a;
  logic [3:0] sum_a;
  logic       rolling_a, valid_a, doubles_a;
  logic [5:0] throw_b;
  logic [3:0] sum_b;
  logic       rolling_b, valid_b, doubles_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  multi_dice #(.N_DICE(2), .FACES(6), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .button(button), .result_ack(result_ack),
    .throw(throw_a), .sum(sum_a), .rolling(rolling_a),
    .result_valid(valid_a), .doubles(doubles_a)
  );

  multi_dice #(.N_DICE(3), .FACES(3), .DEBOUNCE_CYCLES(DEB)) dut3 (
    .clk(clk), .rst(rst), .button(button), .result_ack(result_ack),
    .throw(throw_b), .sum(sum_b), .rolling(rolling_b),
    .result_valid(valid_b), .doubles(doubles_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: button history, debounced level, roll state and the
  // number of stepping edges so far. Die i after k steps is ((k*step) mod F)+1.
  bit m_s1, m_s2, m_db, m_roll, m_valid;
  int m_k;
  bit hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_roll = 0; m_valid = 0; m_k = 0;
      hist.delete();
    end else begin
      bit db_next;
      bit all_diff;
      db_next = m_db;
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        all_diff = 1;
        foreach (hist[j]) if (hist[j] == m_db) all_diff = 0;
        if (all_diff) db_next = !m_db;
      end
      if (!m_roll) begin
        if (m_db) begin
          m_roll = 1; m_valid = 0;
        end else if (result_ack) begin
          m_valid = 0;
        end
      end else begin
        if (m_db) m_k++;
        else begin
          m_roll = 0; m_valid = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = button;
      m_db = db_next;
    end
  end

  function automatic int exp_die(input int i, input int faces, input int k);
    return ((k * ((i % (faces - 1)) + 1)) % faces) + 1;
  endfunction

  task automatic compare_all();
    logic [5:0] ea, eb;
    int sa, sb;
    bit eqa, eqb;
    ea = '0; eb = '0; sa = 0; sb = 0; eqa = 1; eqb = 1;
    for (int i = 0; i < 2; i++) begin
      ea[i*3 +: 3] = 3'(exp_die(i, 6, m_k));
      sa += exp_die(i, 6, m_k);
      if (exp_die(i, 6, m_k) != exp_die(0, 6, m_k)) eqa = 0;
    end
    for (int i = 0; i < 3; i++) begin
      eb[i*2 +: 2] = 2'(exp_die(i, 3, m_k));
      sb += exp_die(i, 3, m_k);
      if (exp_die(i, 3, m_k) != exp_die(0, 3, m_k)) eqb = 0;
    end
    check("a_throw",   32'(throw_a),   32'(ea));
    check("a_sum",     32'(sum_a),     32'(sa));
    check("a_rolling", 32'(rolling_a), 32'(m_roll));
    check("a_valid",   32'(valid_a),   32'(m_valid));
    check("a_doubles", 32'(doubles_a), 32'(m_valid & eqa));
    check("b_throw",   32'(throw_b),   32'(eb));
    check("b_sum",     32'(sum_b),     32'(sb));
    check("b_rolling", 32'(rolling_b), 32'(m_roll));
    check("b_valid",   32'(valid_b),   32'(m_valid));
    check("b_doubles", 32'(doubles_b), 32'(m_valid & eqb));
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; button = 1'b0; result_ack = 1'b0;
    cycles(n);
    rst = 1'b0;
  endtask

  // Button high for exactly h posedges, then low.
  task automatic press(input int h);
    @(negedge clk);
    button = 1'b1;
    cycles(h);
    button = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (valid_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_timeout"}, 32'(valid_a), 32'd1);
  endtask

  initial begin
    int n;
    int hold;
    rst = 1'b1; button = 1'b1; result_ack = 1'b0;

    // Reset held with the button pressed.
    cycles(3);
    chk_en = 1'b1;
    check("rst_throw", 32'(throw_a), 32'h09);
    check("rst_sum",   32'(sum_a),   32'd2);
    check("rst_roll",  32'(rolling_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (rolling_a !== 1'b1 && n < 20);
    check("press_latency", 32'(n), 32'd7);

    // Button has been high for 7 posedges; one more gives 7 stepping edges.
    cycles(2);
    button = 1'b0;
    wait_valid("roll7");
    check("roll7_die0",    32'(throw_a[2:0]), 32'd2);
    check("roll7_die1",    32'(throw_a[5:3]), 32'd3);
    check("roll7_sum",     32'(sum_a),        32'd5);
    check("roll7_doubles", 32'(doubles_a),    32'd0);
    cycles(5);
    check("roll7_held", 32'(valid_a), 32'd1);
    result_ack = 1'b1;
    cycles(1);
    result_ack = 1'b0;
    check("roll7_acked", 32'(valid_a), 32'd0);

    // Short glitch is swallowed.
    do_reset(2);
    press(3);
    cycles(12);
    check("glitch_roll",  32'(rolling_a), 32'd0);
    check("glitch_throw", 32'(throw_a),   32'h09);

    // Six stepping edges bring both dice back to 1.
    do_reset(2);
    press(7);
    wait_valid("roll6");
    check("roll6_throw",   32'(throw_a),   32'h09);
    check("roll6_sum",     32'(sum_a),     32'd2);
    check("roll6_doubles", 32'(doubles_a), 32'd1);

    // 3 dice x 3 faces, four stepping edges.
    do_reset(2);
    press(5);
    wait_valid("b4");
    check("b4_die0", 32'(throw_b[1:0]), 32'd2);
    check("b4_die1", 32'(throw_b[3:2]), 32'd3);
    check("b4_die2", 32'(throw_b[5:4]), 32'd2);
    check("b4_sum",  32'(sum_b),        32'd7);

    // Reset during a roll.
    do_reset(2);
    @(negedge clk);
    button = 1'b1;
    n = 0;
    while (rolling_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_entered", 32'(rolling_a), 32'd1);
    cycles(3);
    rst = 1'b1;
    cycles(1);
    check("midrst_throw", 32'(throw_a),   32'h09);
    check("midrst_roll",  32'(rolling_a), 32'd0);
    check("midrst_valid", 32'(valid_a),   32'd0);
    rst = 1'b0;
    button = 1'b0;
    cycles(10);

    // New press with the previous result unacknowledged; ack lands on entry.
    press(8);
    wait_valid("unacked");
    button = 1'b1;
    n = 0;
    while (!(m_roll == 0 && m_db == 1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    result_ack = 1'b1;
    cycles(1);
    result_ack = 1'b0;
    check("reroll_valid", 32'(valid_a),   32'd0);
    check("reroll_roll",  32'(rolling_a), 32'd1);
    cycles(4);
    button = 1'b0;
    wait_valid("reroll");

    // Random button / ack / occasional reset traffic.
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        button = 1'($urandom_range(1, 0));
        hold = $urandom_range(15, 1);
      end
      hold--;
      result_ack = ($urandom_range(3, 0) == 0);
      rst = ($urandom_range(199, 0) == 0);
    end
    rst = 1'b0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
